// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects six raw push-buttons for the game core.
// Provides direction levels, a toggled pause level and a single-cycle restart pulse.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_MAX = 100000,
   parameter bit          INVERT       = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] i_btn,
   output logic       o_up,
   output logic       o_down,
   output logic       o_left,
   output logic       o_right,
   output logic       o_pause,
   output logic       o_restart,
   output logic [5:0] o_press
);

   localparam int unsigned NB    = 6;
   localparam int unsigned CNT_W = (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

   logic [NB-1:0]    w_raw;
   logic [NB-1:0]    r_s1;
   logic [NB-1:0]    r_s2;
   logic [NB-1:0]    r_db;
   logic [NB-1:0]    r_db_d;
   logic [NB-1:0]    r_press;
   logic             r_pause;
   logic [CNT_W-1:0] r_cnt [NB];

   logic [NB-1:0]    w_db_nxt;
   logic [CNT_W-1:0] w_cnt_nxt [NB];
   logic [NB-1:0]    w_press_nxt;
   logic             w_pause_nxt;

   // Active-low buttons are flipped before the synchroniser so everything downstream is active-high.
   assign w_raw = INVERT ? ~i_btn : i_btn;

   // Per-channel debounce: count consecutive disagreeing cycles, commit on the last one.
   always_comb begin
      w_db_nxt = r_db;
      for (int i = 0; i < NB; i++) begin
         w_cnt_nxt[i] = '0;
         if (r_s2[i] != r_db[i]) begin
            if (r_cnt[i] == CNT_LAST) begin
               w_db_nxt[i] = r_s2[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Restart press overrides a coincident pause press.
   always_comb begin
      w_press_nxt = r_db & ~r_db_d;
      w_pause_nxt = r_pause;
      if (w_press_nxt[5]) begin
         w_pause_nxt = 1'b0;
      end else if (w_press_nxt[4]) begin
         w_pause_nxt = ~r_pause;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_db    <= '0;
         r_db_d  <= '0;
         r_press <= '0;
         r_pause <= 1'b0;
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_s1    <= w_raw;
         r_s2    <= r_s1;
         r_db    <= w_db_nxt;
         r_db_d  <= r_db;
         r_press <= w_press_nxt;
         r_pause <= w_pause_nxt;
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   assign o_up      = r_db[0];
   assign o_down    = r_db[1];
   assign o_left    = r_db[2];
   assign o_right   = r_db[3];
   assign o_pause   = r_pause;
   assign o_restart = r_press[5];
   assign o_press   = r_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench: press pulses are predicted when buttons are driven and matched as they emerge.
module tb_button_conditioner;

   logic       clk;
   logic       rst;
   logic [5:0] i_btn;
   logic       o_up, o_down, o_left, o_right, o_pause, o_restart;
   logic [5:0] o_press;

   logic [5:0] i_btn_n;
   logic       inv_up, inv_down, inv_left, inv_right, inv_pause, inv_restart;
   logic [5:0] inv_press;

   typedef struct {
      int unsigned cyc;
      logic [5:0]  mask;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc;
   int unsigned n_cmp;
   int unsigned n_err;
   int unsigned inv_pulses;

   button_conditioner #(.DEBOUNCE_MAX(4), .INVERT(1'b0)) dut (
      .clk(clk), .rst(rst), .i_btn(i_btn),
      .o_up(o_up), .o_down(o_down), .o_left(o_left), .o_right(o_right),
      .o_pause(o_pause), .o_restart(o_restart), .o_press(o_press)
   );

   button_conditioner #(.DEBOUNCE_MAX(1), .INVERT(1'b1)) dut_inv (
      .clk(clk), .rst(rst), .i_btn(i_btn_n),
      .o_up(inv_up), .o_down(inv_down), .o_left(inv_left), .o_right(inv_right),
      .o_pause(inv_pause), .o_restart(inv_restart), .o_press(inv_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive buttons now; a non-zero mask predicts a press pulse seen 7 samples later.
   task automatic drive(input logic [5:0] v, input logic [5:0] mask);
      i_btn = v;
      if (mask != 6'h0) q.push_back('{cyc + 7, mask});
   endtask

   always @(negedge clk) begin
      if (!rst && o_press != 6'h0) begin
         if (q.size() == 0) begin
            check("press_unexpected", 32'(o_press), 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("press_cyc", cyc, e.cyc);
            check("press_mask", 32'(o_press), 32'(e.mask));
            check("restart_pulse", 32'(o_restart), 32'(e.mask[5]));
         end
      end
      if (!rst && inv_press != 6'h0) inv_pulses++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic seen;
      int unsigned r;
      cyc        = 0;
      n_cmp      = 0;
      n_err      = 0;
      inv_pulses = 0;
      rst        = 1'b1;
      i_btn      = 6'h00;
      i_btn_n    = 6'h3F;
      tick(3);
      check("reset_outs", 32'({o_up, o_down, o_left, o_right, o_pause, o_restart, o_press}), 32'h0);
      check("reset_inv_outs", 32'({inv_up, inv_down, inv_left, inv_right, inv_pause, inv_restart, inv_press}), 32'h0);
      rst = 1'b0;
      tick(5);

      // Clean press and release of up
      drive(6'h01, 6'h01);
      tick(5); check("up_early", 32'(o_up), 32'h0);
      tick(1); check("up_set", 32'(o_up), 32'h1);
      tick(10);
      drive(6'h00, 6'h00);
      tick(5); check("up_rel_early", 32'(o_up), 32'h1);
      tick(1); check("up_rel", 32'(o_up), 32'h0);
      tick(4);

      // Short glitch on left is rejected, then a clean press has full latency
      drive(6'h04, 6'h00);
      tick(3);
      drive(6'h00, 6'h00);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (o_left) seen = 1'b1;
      end
      check("glitch_left", 32'(seen), 32'h0);
      drive(6'h04, 6'h04);
      tick(5); check("left_early", 32'(o_left), 32'h0);
      tick(1); check("left_set", 32'(o_left), 32'h1);
      tick(6);
      drive(6'h00, 6'h00);
      tick(10);

      // Pause toggling, held press toggles once
      drive(6'h10, 6'h10);
      tick(8);  check("pause_on", 32'(o_pause), 32'h1);
      tick(20); check("pause_held", 32'(o_pause), 32'h1);
      drive(6'h00, 6'h00);
      tick(10); check("pause_after_rel", 32'(o_pause), 32'h1);
      drive(6'h10, 6'h10);
      tick(8);  check("pause_off", 32'(o_pause), 32'h0);
      drive(6'h00, 6'h00);
      tick(10);

      // Restart beats a coincident pause press
      drive(6'h10, 6'h10);
      tick(8); check("pause_pre", 32'(o_pause), 32'h1);
      drive(6'h00, 6'h00);
      tick(10);
      drive(6'h30, 6'h30);
      tick(6); check("pause_before_restart", 32'(o_pause), 32'h1);
      tick(1); check("restart_high", 32'(o_restart), 32'h1);
      check("pause_cleared", 32'(o_pause), 32'h0);
      tick(1); check("restart_single", 32'(o_restart), 32'h0);
      check("pause_stays_clear", 32'(o_pause), 32'h0);
      drive(6'h00, 6'h00);
      tick(10);

      // Simultaneous directions
      drive(6'h0F, 6'h0F);
      tick(6); check("dirs_all", 32'({o_right, o_left, o_down, o_up}), 32'hF);
      tick(2);

      // Async reset mid-count with every button held
      drive(6'h3F, 6'h00);
      tick(3);
      #2 rst = 1'b1;
      #1 check("rst_async", 32'({o_up, o_down, o_left, o_right, o_pause, o_restart, o_press}), 32'h0);
      tick(2);
      rst = 1'b0;
      r = cyc;
      q.push_back('{r + 7, 6'h3F});
      tick(5); check("rst_rearm_early", 32'({o_right, o_left, o_down, o_up}), 32'h0);
      tick(1); check("rst_rearm_dirs", 32'({o_right, o_left, o_down, o_up}), 32'hF);
      tick(1); check("rst_rearm_pause", 32'(o_pause), 32'h0);
      tick(5);
      drive(6'h00, 6'h00);
      tick(10);

      // Bouncing release of right
      drive(6'h08, 6'h08);
      tick(8); check("right_set", 32'(o_right), 32'h1);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         i_btn = (k % 2 == 1) ? 6'h08 : 6'h00;
         for (int j = 0; j < 2; j++) begin
            tick(1);
            if (!o_right) seen = 1'b1;
         end
      end
      check("bounce_hold", 32'(seen), 32'h0);
      drive(6'h00, 6'h00);
      tick(5); check("bounce_settle_early", 32'(o_right), 32'h1);
      tick(1); check("bounce_settle", 32'(o_right), 32'h0);
      tick(10);

      // Active-low instance: idle through all of the above, then one press
      check("inv_idle_press", inv_pulses, 32'h0);
      i_btn_n = 6'h3E;
      tick(2); check("inv_up_early", 32'(inv_up), 32'h0);
      tick(1); check("inv_up_set", 32'(inv_up), 32'h1);
      tick(1); check("inv_press", 32'(inv_press), 32'h01);
      tick(1); check("inv_press_single", 32'(inv_press), 32'h00);
      i_btn_n = 6'h3F;
      tick(5);

      check("queue_empty", q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_MAX, default 100000, meaning consecutive stable cycles (after sync) before a debounced level changes; legal range 1..2^20.
REQ-002 SHALL have parameter INVERT, default 0; when 1, all raw button inputs are active-low and are inverted before synchronisation.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_btn, input, 6, raw asynchronous buttons: bit0 up, bit1 down, bit2 left, bit3 right, bit4 pause, bit5 restart.
REQ-006 SHALL have ports o_up, o_down, o_left, o_right, output, 1 each, debounced active-high direction levels for the game's i_up/i_down/i_left/i_right.
REQ-007 SHALL have port o_pause, output, 1, pause state level for the game's i_pause.
REQ-008 SHALL have port o_restart, output, 1, single-cycle restart pulse for the game's i_restart.
REQ-009 SHALL have port o_press, output, 6, single-cycle press-edge pulses per button, same bit order as i_btn.

Function
REQ-010 SHALL pass each (optionally inverted) i_btn bit through a two-flop synchroniser (s1, s2) before any other use.
REQ-011 SHALL keep, per bit, a debounced level db and a counter cnt of width ceil(log2(DEBOUNCE_MAX+1)).
REQ-012 SHALL clear cnt to 0 in any cycle where s2 == db.
REQ-013 SHALL, in a cycle where s2 != db and cnt == DEBOUNCE_MAX-1, load db <= s2 and clear cnt to 0.
REQ-014 SHALL, in a cycle where s2 != db and cnt < DEBOUNCE_MAX-1, increment cnt by 1; cnt never wraps.
REQ-015 SHALL, for a raw change first sampled by s1 at edge 0 and held, update db at edge 1+DEBOUNCE_MAX (DEBOUNCE_MAX=1: edge 2).
REQ-016 SHALL ignore any glitch whose synchronised width is shorter than DEBOUNCE_MAX cycles (db unchanged, cnt returns to 0).
REQ-017 SHALL drive o_up/o_down/o_left/o_right directly from db[0..3]; simultaneous directions pass through unfiltered.
REQ-018 SHALL assert o_press[i] for exactly the cycle after db[i] rises 0->1 (registered rising-edge detect); never on release.
REQ-019 SHALL drive o_restart equal to o_press[5].
REQ-020 SHALL toggle o_pause on the cycle o_press[4] is asserted.
REQ-021 SHALL clear o_pause on the cycle o_press[5] is asserted; restart wins if pause and restart press pulses coincide.
REQ-022 SHALL hold a held button as a single o_press pulse; no auto-repeat.
REQ-023 SHALL treat the six channels independently; activity on one never resets another's cnt or db.

Reset
REQ-024 SHALL, while rst is high, asynchronously force s1, s2, db, cnt, edge-detect registers and o_pause to 0, hence every output to 0.
REQ-025 SHALL, with INVERT=1, reset synchroniser and db to 0 (released state after inversion), so no press pulse fires on reset release with buttons idle.
REQ-026 SHALL, on reset asserted mid-debounce, discard the partial count; a button held through reset release is re-debounced from 0 and produces one o_press pulse DEBOUNCE_MAX+2 edges after release.

Verification (DEBOUNCE_MAX=4, INVERT=0)
REQ-027 Clean press: i_btn[0] 0->1 sampled at edge 0, held -> o_up=1 from edge 5; o_press[0]=1 for exactly one cycle starting at edge 6.
REQ-028 Glitch: i_btn[2]=1 for 3 cycles then 0 -> o_left stays 0, o_press stays 0, cnt back to 0.
REQ-029 Pause toggle: two separate debounced pause presses -> o_pause 0->1 on first pulse, 1->0 on second; held press toggles once only.
REQ-030 Restart priority: o_pause=1, pause and restart pressed in same cycle -> o_restart one-cycle pulse and o_pause=0 after it.
REQ-031 Async reset: rst pulsed mid-count with all buttons held -> all outputs 0 immediately; after release each held button gives one press pulse at edge 6.
REQ-032 Bouncing release: i_btn[3] alternates every 2 cycles for 20 cycles then settles 0 -> o_right changes only after 4 stable cycles, no extra o_press pulses.
